// File: rtl/countdown_timer.sv
// countdown_timer: loadable down-counter with a three-state IDLE/RUN/DONE FSM.
//
// Ports:
//   Clk    - clock, all state updates on its rising edge
//   Clr    - asynchronous active-high reset
//   Load   - captures Din as count and reload value; highest priority, aborts a run
//   Din    - start value (WIDTH bits)
//   Start  - begins or restarts the countdown (ignored while running)
//   Enable - count-step qualifier while running
//   Q      - current count
//   Busy   - high while in RUN
//   Zero   - combinational, (Q == 0)
//   Done   - one-cycle registered pulse on terminal count
//
// Build option: define COUNTDOWN_TIMER_AUTO_RELOAD_EN to reload Q from the
// captured load value at terminal count and keep running instead of stopping.

module countdown_timer #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             Clk,
  input  logic             Clr,
  input  logic             Load,
  input  logic [WIDTH-1:0] Din,
  input  logic             Start,
  input  logic             Enable,
  output logic [WIDTH-1:0] Q,
  output logic             Busy,
  output logic             Zero,
  output logic             Done
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  localparam logic [WIDTH-1:0] CNT_ZERO = '0;
  localparam logic [WIDTH-1:0] CNT_ONE  = WIDTH'(1);

  logic [1:0]       state_q, state_d;
  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] rld_q, rld_d;
  logic             done_q, done_d;
  logic             busy_q, busy_d;

  // State register; Clr forces the idle, zero-count state at once.
  always_ff @(posedge Clk or posedge Clr) begin
    if (Clr) begin
      state_q <= ST_IDLE;
      cnt_q   <= CNT_ZERO;
      rld_q   <= CNT_ZERO;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rld_q   <= rld_d;
      done_q  <= done_d;
      busy_q  <= busy_d;
    end
  end

  // Next-state and next-output logic; Load overrides every state.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rld_d   = rld_q;
    done_d  = 1'b0;

    if (Load) begin
      cnt_d   = Din;
      rld_d   = Din;
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (Start) begin
            if (cnt_q != CNT_ZERO) begin
              state_d = ST_RUN;
            end else begin
              state_d = ST_DONE;
              done_d  = 1'b1;
            end
          end
        end

        ST_RUN: begin
          if (Enable) begin
            if (cnt_q > CNT_ONE) begin
              cnt_d = cnt_q - CNT_ONE;
            end else if (cnt_q == CNT_ONE) begin
`ifdef COUNTDOWN_TIMER_AUTO_RELOAD_EN
              cnt_d  = rld_q;
              done_d = 1'b1;
`else
              cnt_d   = CNT_ZERO;
              state_d = ST_DONE;
              done_d  = 1'b1;
`endif
            end
            // A zero count is never decremented, so the counter cannot wrap.
          end
        end

        ST_DONE: begin
          if (Start) begin
            if (rld_q != CNT_ZERO) begin
              cnt_d   = rld_q;
              state_d = ST_RUN;
            end else begin
              done_d = 1'b1;
            end
          end
        end

        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end

    // Busy is registered alongside the state so it tracks RUN exactly.
    busy_d = (state_d == ST_RUN);
  end

  assign Q    = cnt_q;
  assign Busy = busy_q;
  assign Done = done_q;
  assign Zero = (cnt_q == CNT_ZERO);

endmodule

// File: tb/tb_countdown_timer.sv
module tb_countdown_timer;

  localparam int unsigned WIDTH = 8;

  logic             Clk;
  logic             Clr;
  logic             Load;
  logic [WIDTH-1:0] Din;
  logic             Start;
  logic             Enable;
  logic [WIDTH-1:0] Q;
  logic             Busy;
  logic             Zero;
  logic             Done;

  countdown_timer #(.WIDTH(WIDTH)) dut (
    .Clk    (Clk),
    .Clr    (Clr),
    .Load   (Load),
    .Din    (Din),
    .Start  (Start),
    .Enable (Enable),
    .Q      (Q),
    .Busy   (Busy),
    .Zero   (Zero),
    .Done   (Done)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: remaining count, reload value and a coarse activity mode.
  localparam int M_IDLE = 0;
  localparam int M_RUN  = 1;
  localparam int M_DONE = 2;
  int m_q    = 0;
  int m_rld  = 0;
  int m_mode = M_IDLE;
  int m_done = 0;

  function automatic void model_reset();
    m_q = 0; m_rld = 0; m_mode = M_IDLE; m_done = 0;
  endfunction

  function automatic void model_step(input int ld, input int d, input int st, input int en);
    m_done = 0;
    if (ld != 0) begin
      m_q = d; m_rld = d; m_mode = M_IDLE;
    end else if (m_mode == M_IDLE) begin
      if (st != 0) begin
        if (m_q > 0) m_mode = M_RUN;
        else begin m_mode = M_DONE; m_done = 1; end
      end
    end else if (m_mode == M_RUN) begin
      if (en != 0 && m_q > 0) begin
        m_q = m_q - 1;
        if (m_q == 0) begin
          m_done = 1;
`ifdef COUNTDOWN_TIMER_AUTO_RELOAD_EN
          m_q = m_rld;
`else
          m_mode = M_DONE;
`endif
        end
      end
    end else begin
      if (st != 0) begin
        if (m_rld > 0) begin m_q = m_rld; m_mode = M_RUN; end
        else m_done = 1;
      end
    end
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // One clock: drive inputs, advance the model, then compare after the edge.
  task automatic cycle(input string tag, input logic ld, input logic [WIDTH-1:0] d,
                       input logic st, input logic en);
    Load = ld; Din = d; Start = st; Enable = en;
    model_step(int'(ld), int'(d), int'(st), int'(en));
    @(posedge Clk);
    #1;
    chk({tag, ".q"},    int'(Q),    m_q);
    chk({tag, ".busy"}, int'(Busy), (m_mode == M_RUN) ? 1 : 0);
    chk({tag, ".zero"}, int'(Zero), (m_q == 0) ? 1 : 0);
    chk({tag, ".done"}, int'(Done), m_done);
  endtask

  // Asynchronous clear mid-cycle; effect must be visible before the next edge.
  task automatic async_clr(input string tag);
    #3;
    Clr = 1'b1;
    #1;
    model_reset();
    chk({tag, ".clr_q"},    int'(Q),    0);
    chk({tag, ".clr_busy"}, int'(Busy), 0);
    chk({tag, ".clr_zero"}, int'(Zero), 1);
    chk({tag, ".clr_done"}, int'(Done), 0);
    #2;
    Clr = 1'b0;
  endtask

  typedef struct {
    logic             ld;
    logic [WIDTH-1:0] d;
    logic             st;
    logic             en;
    logic [WIDTH-1:0] q;
    logic             busy;
    logic             done;
  } vec_t;

  vec_t tbl[11];
  int   n_vec;

  initial begin
    int first_done;
    int n;

    Clr = 1'b1; Load = 1'b0; Din = '0; Start = 1'b0; Enable = 1'b0;
    model_reset();
    #12;
    chk("reset.q",    int'(Q),    0);
    chk("reset.busy", int'(Busy), 0);
    chk("reset.zero", int'(Zero), 1);
    chk("reset.done", int'(Done), 0);
    #1;
    Clr = 1'b0;

    // Directed table: basic countdown, or periodic reload when built with it.
`ifdef COUNTDOWN_TIMER_AUTO_RELOAD_EN
    tbl[0] = '{1'b1, 8'd3, 1'b0, 1'b1, 8'd3, 1'b0, 1'b0};
    tbl[1] = '{1'b0, 8'd0, 1'b1, 1'b1, 8'd3, 1'b1, 1'b0};
    tbl[2] = '{1'b0, 8'd0, 1'b0, 1'b1, 8'd2, 1'b1, 1'b0};
    tbl[3] = '{1'b0, 8'd0, 1'b0, 1'b1, 8'd1, 1'b1, 1'b0};
    tbl[4] = '{1'b0, 8'd0, 1'b0, 1'b1, 8'd3, 1'b1, 1'b1};
    tbl[5] = '{1'b0, 8'd0, 1'b0, 1'b1, 8'd2, 1'b1, 1'b0};
    tbl[6] = '{1'b0, 8'd0, 1'b0, 1'b1, 8'd1, 1'b1, 1'b0};
    tbl[7] = '{1'b0, 8'd0, 1'b0, 1'b1, 8'd3, 1'b1, 1'b1};
    tbl[8] = '{1'b0, 8'd0, 1'b0, 1'b1, 8'd2, 1'b1, 1'b0};
    tbl[9] = '{1'b0, 8'd0, 1'b0, 1'b1, 8'd1, 1'b1, 1'b0};
    tbl[10] = '{1'b0, 8'd0, 1'b0, 1'b1, 8'd3, 1'b1, 1'b1};
    n_vec = 11;
`else
    tbl[0] = '{1'b1, 8'd5, 1'b0, 1'b1, 8'd5, 1'b0, 1'b0};
    tbl[1] = '{1'b0, 8'd0, 1'b1, 1'b1, 8'd5, 1'b1, 1'b0};
    tbl[2] = '{1'b0, 8'd0, 1'b0, 1'b1, 8'd4, 1'b1, 1'b0};
    tbl[3] = '{1'b0, 8'd0, 1'b0, 1'b1, 8'd3, 1'b1, 1'b0};
    tbl[4] = '{1'b0, 8'd0, 1'b0, 1'b1, 8'd2, 1'b1, 1'b0};
    tbl[5] = '{1'b0, 8'd0, 1'b0, 1'b1, 8'd1, 1'b1, 1'b0};
    tbl[6] = '{1'b0, 8'd0, 1'b0, 1'b1, 8'd0, 1'b0, 1'b1};
    tbl[7] = '{1'b0, 8'd0, 1'b0, 1'b1, 8'd0, 1'b0, 1'b0};
    tbl[8] = '{1'b0, 8'd0, 1'b0, 1'b1, 8'd0, 1'b0, 1'b0};
    n_vec = 9;
`endif
    for (int i = 0; i < n_vec; i++) begin
      cycle("tbl", tbl[i].ld, tbl[i].d, tbl[i].st, tbl[i].en);
      chk($sformatf("tbl[%0d].q", i),    int'(Q),    int'(tbl[i].q));
      chk($sformatf("tbl[%0d].busy", i), int'(Busy), int'(tbl[i].busy));
      chk($sformatf("tbl[%0d].done", i), int'(Done), int'(tbl[i].done));
    end

    // Enable gating: terminal event only on the last enabled step.
    cycle("gate", 1'b1, 8'd3, 1'b0, 1'b0);
    cycle("gate", 1'b0, 8'd0, 1'b1, 1'b0);
    cycle("gate", 1'b0, 8'd0, 1'b0, 1'b1);
    cycle("gate", 1'b0, 8'd0, 1'b0, 1'b0);
    cycle("gate", 1'b0, 8'd0, 1'b0, 1'b0);
    chk("gate.hold_q", int'(Q), 2);
    cycle("gate", 1'b0, 8'd0, 1'b0, 1'b1);
    cycle("gate", 1'b0, 8'd0, 1'b0, 1'b1);
    chk("gate.final_done", int'(Done), 1);

    // Load aborts a run and beats a simultaneous Start.
    cycle("abort", 1'b1, 8'd200, 1'b0, 1'b0);
    cycle("abort", 1'b0, 8'd0, 1'b1, 1'b1);
    for (int i = 0; i < 10; i++) cycle("abort", 1'b0, 8'd0, 1'b0, 1'b1);
    chk("abort.q190", int'(Q), 190);
    cycle("abort", 1'b1, 8'd7, 1'b1, 1'b1);
    chk("abort.q7",   int'(Q),    7);
    chk("abort.busy", int'(Busy), 0);
    chk("abort.done", int'(Done), 0);

    // Zero start pulses Done without running, then a normal restart.
    cycle("zero", 1'b1, 8'd0, 1'b0, 1'b1);
    cycle("zero", 1'b0, 8'd0, 1'b1, 1'b1);
    chk("zero.done", int'(Done), 1);
    chk("zero.busy", int'(Busy), 0);
    cycle("zero", 1'b0, 8'd0, 1'b0, 1'b1);
    chk("zero.done_once", int'(Done), 0);
    cycle("zero", 1'b0, 8'd0, 1'b1, 1'b1);
    chk("zero.repulse", int'(Done), 1);
    cycle("restart", 1'b1, 8'd2, 1'b0, 1'b1);
    cycle("restart", 1'b0, 8'd0, 1'b1, 1'b1);
    cycle("restart", 1'b0, 8'd0, 1'b0, 1'b1);
    cycle("restart", 1'b0, 8'd0, 1'b0, 1'b1);
    chk("restart.done1", int'(Done), 1);
    cycle("restart", 1'b0, 8'd0, 1'b1, 1'b1);
    chk("restart.q2", int'(Q), 2);
    cycle("restart", 1'b0, 8'd0, 1'b0, 1'b1);
    cycle("restart", 1'b0, 8'd0, 1'b0, 1'b1);
    chk("restart.done2", int'(Done), 1);

    // Asynchronous clear in the middle of a run.
    cycle("aclr", 1'b1, 8'd9, 1'b0, 1'b0);
    cycle("aclr", 1'b0, 8'd0, 1'b1, 1'b1);
    for (int i = 0; i < 5; i++) cycle("aclr", 1'b0, 8'd0, 1'b0, 1'b1);
    chk("aclr.q4", int'(Q), 4);
    async_clr("aclr");
    cycle("aclr_post", 1'b0, 8'd0, 1'b0, 1'b1);
    chk("aclr.no_done", int'(Done), 0);

    // Latency: Done exactly N cycles after Start, with a bounded wait.
    for (int t = 0; t < 4; t++) begin
      n = int'($urandom_range(1, 20));
      cycle("lat", 1'b1, WIDTH'(n), 1'b0, 1'b1);
      cycle("lat", 1'b0, 8'd0, 1'b1, 1'b1);
      first_done = 0;
      for (int k = 1; k <= n + 5; k++) begin
        cycle("lat", 1'b0, 8'd0, 1'b0, 1'b1);
        if (Done && first_done == 0) first_done = k;
      end
      chk($sformatf("lat.n%0d", n), first_done, n);
    end

    // Randomized traffic against the model.
    for (int i = 0; i < 2000; i++) begin
      logic             r_ld;
      logic [WIDTH-1:0] r_d;
      logic             r_st;
      logic             r_en;
      r_ld = ($urandom_range(0, 15) == 0);
      r_d  = ($urandom_range(0, 3) == 0) ? WIDTH'($urandom_range(0, 255))
                                         : WIDTH'($urandom_range(0, 4));
      r_st = ($urandom_range(0, 3) == 0);
      r_en = ($urandom_range(0, 3) != 0);
      cycle("rnd", r_ld, r_d, r_st, r_en);
      if ($urandom_range(0, 199) == 0) async_clr("rnd");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
